polycoff_bank_ram: RTL and testbench

//  Parametrised multi-bank true-dual-port coefficient memory for the NTT datapath.
//  NUM_BANKS independent banks of DEPTH x DLEN, each with two read/write ports.

---
 rtl/polycoff_bank_ram_pkg.sv | 15 +
 rtl/polycoff_bank_ram_if.sv | 36 +++
 rtl/polycoff_bank_core.sv | 86 ++++++++
 rtl/polycoff_bank_ram.sv | 97 +++++++++
 tb/tb_polycoff_bank_ram.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/polycoff_bank_ram_pkg.sv
// Shared types and default sizing for the multi-bank coefficient memory.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package polycoff_ram_pkg;

    localparam int DEF_DLEN      = 32;
    localparam int DEF_HLEN      = 7;
    localparam int DEF_NUM_BANKS = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_t;

endpackage

// File: rtl/polycoff_bank_ram_if.sv
// Bus bundle between the NTT address generator and the coefficient banks.
// Latency: n/a (wires only).
// Backpressure: none; clr_busy tells the master that its accesses are dropped.
interface polycoff_bank_ram_if
    import polycoff_ram_pkg::*;
#(
    parameter int DLEN      = DEF_DLEN,
    parameter int HLEN      = DEF_HLEN,
    parameter int NUM_BANKS = DEF_NUM_BANKS
);
    logic [NUM_BANKS-1:0]      en;
    logic [NUM_BANKS-1:0]      we_a;
    logic [NUM_BANKS-1:0]      we_b;
    logic [NUM_BANKS*HLEN-1:0] addr_a;
    logic [NUM_BANKS*HLEN-1:0] addr_b;
    logic [NUM_BANKS*DLEN-1:0] di_a;
    logic [NUM_BANKS*DLEN-1:0] di_b;
    logic [NUM_BANKS*DLEN-1:0] do_a;
    logic [NUM_BANKS*DLEN-1:0] do_b;
    logic [NUM_BANKS-1:0]      rd_valid;
    logic                      clr_start;
    logic                      clr_busy;
    logic                      clr_done;
    logic [NUM_BANKS-1:0]      collision;

    modport master (
        output en, we_a, we_b, addr_a, addr_b, di_a, di_b, clr_start,
        input  do_a, do_b, rd_valid, clr_busy, clr_done, collision
    );

    modport slave (
        input  en, we_a, we_b, addr_a, addr_b, di_a, di_b, clr_start,
        output do_a, do_b, rd_valid, clr_busy, clr_done, collision
    );

endinterface

// File: rtl/polycoff_bank_core.sv
// One true-dual-port read-first bank with sticky same-address write detect.
// Latency: 1 cycle read, 2 with POLYCOFF_OUTREG_EN; collision flag 1 cycle.
// Backpressure: none; rd_en low holds the outputs.
module polycoff_bank_core #(
    parameter int DLEN = 32,
    parameter int HLEN = 7
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            rd_en,
    input  logic            we_a,
    input  logic            we_b,
    input  logic            coll_clr,
    input  logic [HLEN-1:0] addr_a,
    input  logic [HLEN-1:0] addr_b,
    input  logic [DLEN-1:0] di_a,
    input  logic [DLEN-1:0] di_b,
    output logic [DLEN-1:0] do_a,
    output logic [DLEN-1:0] do_b,
    output logic            rd_valid,
    output logic            collision
);
    localparam int DEPTH = 1 << HLEN;

    (* ram_style = "block" *) logic [DLEN-1:0] mem [DEPTH];

    logic [DLEN-1:0] q_a;
    logic [DLEN-1:0] q_b;
    logic            q_vld;

    // Port A is written last so it wins a same-address collision.
    always_ff @(posedge clk) begin
        if (we_b) mem[addr_b] <= di_b;
        if (we_a) mem[addr_a] <= di_a;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q_a   <= '0;
            q_b   <= '0;
            q_vld <= 1'b0;
        end else begin
            q_vld <= rd_en;
            if (rd_en) begin
                q_a <= mem[addr_a];
                q_b <= mem[addr_b];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || coll_clr)
            collision <= 1'b0;
        else if (we_a && we_b && (addr_a == addr_b))
            collision <= 1'b1;
    end

`ifdef POLYCOFF_OUTREG_EN
    logic [DLEN-1:0] r_a;
    logic [DLEN-1:0] r_b;
    logic            r_vld;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_a   <= '0;
            r_b   <= '0;
            r_vld <= 1'b0;
        end else begin
            r_vld <= q_vld;
            if (q_vld) begin
                r_a <= q_a;
                r_b <= q_b;
            end
        end
    end

    assign do_a     = r_a;
    assign do_b     = r_b;
    assign rd_valid = r_vld;
`else
    assign do_a     = q_a;
    assign do_b     = q_b;
    assign rd_valid = q_vld;
`endif

endmodule

// File: rtl/polycoff_bank_ram.sv
// Multi-bank dual-port coefficient RAM with clear engine; option POLYCOFF_OUTREG_EN.
// Latency: 1 cycle read (2 with POLYCOFF_OUTREG_EN); clear takes 2**HLEN cycles.
// Backpressure: user accesses silently dropped while clr_busy is high.
module polycoff_bank_ram
    import polycoff_ram_pkg::*;
#(
    parameter int DLEN      = DEF_DLEN,
    parameter int HLEN      = DEF_HLEN,
    parameter int NUM_BANKS = DEF_NUM_BANKS
) (
    input  logic                clk,
    input  logic                reset,
    polycoff_bank_ram_if.slave  bus
);
    localparam int            DEPTH = 1 << HLEN;
    localparam logic [HLEN:0] LAST  = (HLEN+1)'(DEPTH - 1);

    clr_state_t    state;
    clr_state_t    state_d;
    logic [HLEN:0] cnt;
    logic [HLEN:0] cnt_d;
    logic          accept;
    logic          done;
    logic          clr_wr;
    logic          user_ok;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        accept  = 1'b0;
        done    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.clr_start) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                    accept  = 1'b1;
                end
            end
            CLEAR: begin
                cnt_d = cnt + 1'b1;
                if (cnt == LAST) begin
                    state_d = IDLE;
                    done    = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Reset blocks the in-flight clear write so an aborted clear stops exactly at cnt.
    assign clr_wr       = ~reset & (state == CLEAR);
    assign user_ok      = ~reset & (state == IDLE);
    assign bus.clr_busy = (state == CLEAR);
    assign bus.clr_done = done & ~reset;

    for (genvar k = 0; k < NUM_BANKS; k++) begin : g_bank
        logic            user_en;
        logic [HLEN-1:0] a_addr;
        logic [DLEN-1:0] a_data;

        assign user_en = user_ok & bus.en[k];
        assign a_addr  = clr_wr ? cnt[HLEN-1:0] : bus.addr_a[k*HLEN +: HLEN];
        assign a_data  = clr_wr ? '0 : bus.di_a[k*DLEN +: DLEN];

        polycoff_bank_core #(
            .DLEN (DLEN),
            .HLEN (HLEN)
        ) u_core (
            .clk       (clk),
            .reset     (reset),
            .rd_en     (user_en),
            .we_a      (clr_wr | (user_en & bus.we_a[k])),
            .we_b      (user_en & bus.we_b[k]),
            .coll_clr  (accept),
            .addr_a    (a_addr),
            .addr_b    (bus.addr_b[k*HLEN +: HLEN]),
            .di_a      (a_data),
            .di_b      (bus.di_b[k*DLEN +: DLEN]),
            .do_a      (bus.do_a[k*DLEN +: DLEN]),
            .do_b      (bus.do_b[k*DLEN +: DLEN]),
            .rd_valid  (bus.rd_valid[k]),
            .collision (bus.collision[k])
        );
    end

endmodule

// File: tb/tb_polycoff_bank_ram.sv
// Directed bench for polycoff_bank_ram at 32/7/4: access, read-first, collision, clear engine.
module tb_polycoff_bank_ram;

`ifdef POLYCOFF_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic clk = 1'b0;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    polycoff_bank_ram_if #(.DLEN(32), .HLEN(7), .NUM_BANKS(4)) bus ();

    polycoff_bank_ram #(.DLEN(32), .HLEN(7), .NUM_BANKS(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.en        = '0;
        bus.we_a      = '0;
        bus.we_b      = '0;
        bus.addr_a    = '0;
        bus.addr_b    = '0;
        bus.di_a      = '0;
        bus.di_b      = '0;
        bus.clr_start = 1'b0;
    endtask

    task automatic drive_a(input int k, input int a, input logic [31:0] d, input logic w);
        bus.en[k]             = 1'b1;
        bus.we_a[k]           = w;
        bus.addr_a[k*7 +: 7]  = 7'(a);
        bus.di_a[k*32 +: 32]  = d;
    endtask

    task automatic drive_b(input int k, input int a, input logic [31:0] d, input logic w);
        bus.en[k]             = 1'b1;
        bus.we_b[k]           = w;
        bus.addr_b[k*7 +: 7]  = 7'(a);
        bus.di_b[k*32 +: 32]  = d;
    endtask

    function automatic logic [31:0] get_a(input int k);
        return bus.do_a[k*32 +: 32];
    endfunction

    function automatic logic [31:0] get_b(input int k);
        return bus.do_b[k*32 +: 32];
    endfunction

    function automatic logic [31:0] pat(input int k, input int a);
        return {16'hC0DE, 8'(k), 8'(a)};
    endfunction

    // Every bank gets pat(k, addr) at all 128 addresses, two addresses per cycle.
    task automatic fill();
        for (int i = 0; i < 64; i++) begin
            for (int k = 0; k < 4; k++) begin
                drive_a(k, i, pat(k, i), 1'b1);
                drive_b(k, i + 64, pat(k, i + 64), 1'b1);
            end
            step();
            idle();
        end
        repeat (2) step();
    endtask

    // Addresses below upto are expected zero, the rest still hold pat().
    task automatic verify_all(input int upto, output int errs);
        logic [31:0] ea, eb;
        errs = 0;
        for (int i = 0; i < 64; i++) begin
            for (int k = 0; k < 4; k++) begin
                drive_a(k, i, 32'h0, 1'b0);
                drive_b(k, i + 64, 32'h0, 1'b0);
            end
            step();
            idle();
            repeat (LAT - 1) step();
            for (int k = 0; k < 4; k++) begin
                ea = (i < upto)      ? 32'h0 : pat(k, i);
                eb = (i + 64 < upto) ? 32'h0 : pat(k, i + 64);
                if (get_a(k) !== ea) errs++;
                if (get_b(k) !== eb) errs++;
            end
        end
    endtask

    initial begin
        int n, done_at, done_cnt, errs;
        logic rv_seen, done_seen, coll_seen;

        reset = 1'b1;
        idle();
        repeat (3) step();
        reset = 1'b0;
        chk("rst_do_a",      64'(bus.do_a == '0), 64'd1);
        chk("rst_do_b",      64'(bus.do_b == '0), 64'd1);
        chk("rst_rd_valid",  64'(bus.rd_valid), 64'h0);
        chk("rst_clr_busy",  64'(bus.clr_busy), 64'h0);
        chk("rst_clr_done",  64'(bus.clr_done), 64'h0);
        chk("rst_collision", 64'(bus.collision), 64'h0);

        // Write via A, then read back via B
        drive_a(2, 5, 32'hDEADBEEF, 1'b1);
        step();
        idle();
        drive_b(2, 5, 32'h0, 1'b0);
        step();
        idle();
        repeat (LAT - 1) step();
        chk("t1_do_b",     64'(get_b(2)), 64'hDEADBEEF);
        chk("t1_rd_valid", 64'(bus.rd_valid), 64'h4);
        step();
        chk("t1_rv_drop",  64'(bus.rd_valid), 64'h0);
        chk("t1_hold",     64'(get_b(2)), 64'hDEADBEEF);

        // Read-first: B reads the word A is overwriting
        drive_a(0, 9, 32'h11, 1'b1);
        step();
        idle();
        drive_a(0, 9, 32'h22, 1'b1);
        drive_b(0, 9, 32'h0, 1'b0);
        step();
        idle();
        repeat (LAT - 1) step();
        chk("t2_b_old",   64'(get_b(0)), 64'h11);
        chk("t2_a_old",   64'(get_a(0)), 64'h11);
        chk("t2_no_coll", 64'(bus.collision), 64'h0);
        drive_b(0, 9, 32'h0, 1'b0);
        step();
        idle();
        repeat (LAT - 1) step();
        chk("t2_b_new",   64'(get_b(0)), 64'h22);

        // Both ports write the same address
        drive_a(1, 3, 32'hAAAA, 1'b1);
        drive_b(1, 3, 32'hBBBB, 1'b1);
        step();
        idle();
        chk("t3_coll_set", 64'(bus.collision), 64'h2);
        drive_a(1, 3, 32'h0, 1'b0);
        step();
        idle();
        repeat (LAT - 1) step();
        chk("t3_a_wins",    64'(get_a(1)), 64'hAAAA);
        repeat (3) step();
        chk("t3_coll_hold", 64'(bus.collision), 64'h2);

        // Full clear
        fill();
        bus.clr_start = 1'b1;
        step();
        bus.clr_start = 1'b0;
        chk("t4_busy_on",   64'(bus.clr_busy), 64'h1);
        chk("t4_coll_clr",  64'(bus.collision), 64'h0);
        n = 0; done_at = -1; done_cnt = 0; rv_seen = 1'b0;
        while (bus.clr_busy && n < 300) begin
            n++;
            if (bus.clr_done) begin
                done_at = n;
                done_cnt++;
            end
            rv_seen |= |bus.rd_valid;
            step();
        end
        chk("t4_busy_cycles", 64'(n), 64'd128);
        chk("t4_done_at",     64'(done_at), 64'd128);
        chk("t4_done_cnt",    64'(done_cnt), 64'd1);
        chk("t4_no_rv",       64'(rv_seen), 64'h0);
        chk("t4_done_low",    64'(bus.clr_done), 64'h0);
        verify_all(128, errs);
        chk("t4_all_zero",    64'(errs), 64'h0);

        // Reset aborts a clear at counter 40
        fill();
        bus.clr_start = 1'b1;
        step();
        bus.clr_start = 1'b0;
        done_seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            done_seen |= bus.clr_done;
            step();
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("t5_busy_off", 64'(bus.clr_busy), 64'h0);
        chk("t5_do_rst",   64'(bus.do_a == '0), 64'd1);
        for (int i = 0; i < 5; i++) begin
            done_seen |= bus.clr_done;
            step();
        end
        chk("t5_no_done",  64'(done_seen), 64'h0);
        verify_all(40, errs);
        chk("t5_partial",  64'(errs), 64'h0);

        // User writes and a second clr_start are ignored during CLEAR
        fill();
        bus.clr_start = 1'b1;
        step();
        bus.clr_start = 1'b0;
        n = 0; done_at = -1; done_cnt = 0; coll_seen = 1'b0;
        while (bus.clr_busy && n < 300) begin
            n++;
            if (bus.clr_done) begin
                done_at = n;
                done_cnt++;
            end
            coll_seen |= |bus.collision;
            for (int k = 0; k < 4; k++) begin
                drive_a(k, 3, 32'h55, 1'b1);
                drive_b(k, 3, 32'h55, 1'b1);
            end
            bus.clr_start = (n == 11);
            step();
        end
        idle();
        chk("t6_busy_cycles", 64'(n), 64'd128);
        chk("t6_done_at",     64'(done_at), 64'd128);
        chk("t6_done_cnt",    64'(done_cnt), 64'd1);
        chk("t6_no_coll",     64'(coll_seen | (|bus.collision)), 64'h0);
        verify_all(128, errs);
        chk("t6_all_zero",    64'(errs), 64'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
